// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]                           req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   start,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]   idx,
    output logic                                   valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    int unsigned cand;

    // Scan N positions starting at the pointer; the first requester wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (int'(start) + i) % N;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Optional feature: define DMEM_ARB_LOCK_EN to add core_lock for atomic sequences.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CORES-1:0]                 core_req,
    input  logic [NUM_CORES-1:0]                 core_wr_en,
    input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NUM_CORES-1:0]                 core_lock,
`endif
    output logic [NUM_CORES-1:0]                 core_gnt,
    output logic [NUM_CORES-1:0]                 core_rvalid,
    output logic [DATA_WIDTH-1:0]                core_rdata,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic                                 mem_wr_en,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    output logic                                 busy
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_t            state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         sel;
    logic                  wr_q;
    logic [PW-1:0]         win_idx;
    logic                  win_valid;
    logic [PW-1:0]         next_ptr;
    logic [NUM_CORES-1:0]  sel_onehot;
    logic [NUM_CORES-1:0]  req_eff;

`ifdef DMEM_ARB_LOCK_EN
    logic locked;
    logic lock_hold;

    // Lock only persists while the owning core keeps core_lock raised.
    assign lock_hold = locked && core_lock[sel];
`endif

    // Decode the selected core and mask requests while a lock is held.
    always_comb begin
        sel_onehot      = '0;
        sel_onehot[sel] = 1'b1;
`ifdef DMEM_ARB_LOCK_EN
        req_eff = lock_hold ? (core_req & sel_onehot) : core_req;
`else
        req_eff = core_req;
`endif
        next_ptr = (win_idx == PW'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
    end

    rr_pick #(.N(NUM_CORES)) u_pick (
        .req   (req_eff),
        .start (rr_ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // FSM and registered access; mem_addr/mem_wdata are loaded on a win and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            sel       <= '0;
            wr_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
                    locked <= lock_hold;
`endif
                    if (win_valid) begin
                        sel       <= win_idx;
                        mem_addr  <= core_addr[win_idx];
                        mem_wdata <= core_wdata[win_idx];
                        wr_q      <= core_wr_en[win_idx];
                        state     <= ARB_ACCESS;
`ifdef DMEM_ARB_LOCK_EN
                        locked    <= core_lock[win_idx];
                        if (!lock_hold) begin
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr    <= next_ptr;
`endif
                    end
                end
                ARB_ACCESS: state <= wr_q ? ARB_IDLE : ARB_RESP;
                ARB_RESP:   state <= ARB_IDLE;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

    // State-qualified strobes and read-data pass-through.
    always_comb begin
        mem_wr_en   = (state == ARB_ACCESS) && wr_q;
        core_gnt    = (state == ARB_ACCESS) ? sel_onehot : '0;
        core_rvalid = (state == ARB_RESP) ? sel_onehot : '0;
        core_rdata  = mem_rdata;
        busy        = (state != ARB_IDLE);
    end

endmodule
